// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, divisor clamp and per-channel flag struct for clk_div_sched
package clk_div_pkg;
  localparam int unsigned MIN_DIV = 2;
  typedef struct packed {
    logic en;
    logic pend;
    logic en_pend;
  } chan_flags_t;
  function automatic int unsigned clamp_div(int unsigned d);
    return d < MIN_DIV ? MIN_DIV : d;
  endfunction
endpackage

// File: rtl/clk_div_sched_if.sv
// clk_div_sched_if: valid/ready configuration port for the divider scheduler
interface clk_div_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 16
);
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic           cfg_en;
  modport master(output cfg_valid, cfg_ch, cfg_div, cfg_en, input cfg_ready);
  modport slave(input cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with boundary-deferred reprogramming and registered outputs
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DW      = 16,
  parameter int DEF_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc,
  input  logic [DW-1:0] new_div,
  input  logic          new_en,
  output logic          div_out,
  output logic          tick,
  output logic          busy
);
  logic [DW-1:0] cnt, div_act, div_pend;
  logic [DW-1:0] cnt_n, div_n, div_pend_n;
  chan_flags_t   f, f_n;
  logic          wrap, apply_now, apply_pend, defer;
  // next state: idle or wrapping channels take updates at once, running ones defer to the wrap
  always_comb begin
    wrap       = f.en & (cnt == div_act - 1'b1);
    apply_now  = acc & (~f.en | wrap);
    apply_pend = f.pend & wrap;
    defer      = acc & f.en & ~wrap;
    div_n      = apply_now ? new_div : apply_pend ? div_pend : div_act;
    f_n.en     = apply_now ? new_en : apply_pend ? f.en_pend : f.en;
    f_n.pend   = defer ? 1'b1 : apply_pend ? 1'b0 : f.pend;
    f_n.en_pend = defer ? new_en : f.en_pend;
    div_pend_n = defer ? new_div : div_pend;
    cnt_n      = (~f_n.en | ~f.en | wrap) ? '0 : cnt + 1'b1;
  end
  // state and output registers; outputs are derived from next state so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_act  <= DW'(DEF_DIV);
      div_pend <= '0;
      f        <= '0;
      tick     <= 1'b0;
      div_out  <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      div_act  <= div_n;
      div_pend <= div_pend_n;
      f        <= f_n;
      tick     <= f_n.en & (cnt_n == '0);
      div_out  <= f_n.en & (cnt_n < (div_n >> 1));
    end
  end
  assign busy = f.pend;
endmodule

// File: rtl/clk_div_sched.sv
// clk_div_sched: NCH-channel clock-enable/divided-clock scheduler with a shared config port
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int DEF_DIV = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  clk_div_sched_if.slave         cfg,
  output logic [NCH-1:0]         div_out,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         busy
);
  localparam int CHW  = NCH > 1 ? $clog2(NCH) : 1;
  localparam int NPAD = 2 ** CHW;
  logic [NPAD-1:0] busy_ext;
  logic [DW-1:0]   div_c;
  assign busy_ext      = NPAD'(busy);
  assign cfg.cfg_ready = ~busy_ext[cfg.cfg_ch];
  assign div_c         = DW'(clamp_div(32'(cfg.cfg_div)));
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(.DW(DW), .DEF_DIV(DEF_DIV)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .acc     (cfg.cfg_valid & cfg.cfg_ready & (cfg.cfg_ch == CHW'(i))),
      .new_div (div_c),
      .new_en  (cfg.cfg_en),
      .div_out (div_out[i]),
      .tick    (tick[i]),
      .busy    (busy[i])
    );
  end
endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: table vectors, corner sequences and random traffic against a period model
module tb_clk_div_sched;
  localparam int NCH = 4;
  localparam int DW  = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] div_out, tick, busy;
  logic [NCH-1:0] s_div, s_tick, s_busy;
  logic s_ready;
  int checks = 0, errors = 0;
  int n[NCH], on[NCH], age[NCH], hp[NCH], pn[NCH], pe[NCH];

  clk_div_sched_if #(.NCH(NCH), .DW(DW)) bus ();
  clk_div_sched #(.NCH(NCH), .DW(DW), .DEF_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(bus), .div_out(div_out), .tick(tick), .busy(busy)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic v; logic [1:0] ch; logic [15:0] d; logic e;
    logic [3:0] xd, xt, xb; logic xr;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, x);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      n[c] = 2; on[c] = 0; age[c] = 0; hp[c] = 0; pn[c] = 0; pe[c] = 0;
    end
  endtask

  // model: a period lasts n cycles from age 0; updates land at a period end (or at once if idle)
  task automatic m_step(input logic v, input int ch, input int d, input logic e);
    int dc;
    bit acc, bnd;
    dc  = d < 2 ? 2 : d;
    acc = v && (ch >= NCH || hp[ch] == 0);
    for (int c = 0; c < NCH; c++) begin
      bnd = on[c] != 0 && age[c] == n[c] - 1;
      if (acc && ch == c && (on[c] == 0 || bnd)) begin
        n[c] = dc; on[c] = e; age[c] = 0;
      end else begin
        if (acc && ch == c) begin hp[c] = 1; pn[c] = dc; pe[c] = e; end
        if (bnd) begin
          if (hp[c] != 0) begin n[c] = pn[c]; on[c] = pe[c]; hp[c] = 0; end
          age[c] = 0;
        end else if (on[c] != 0) age[c]++;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] ch, input logic [15:0] d, input logic e);
    logic [3:0] ed, et, eb;
    bus.cfg_valid = v; bus.cfg_ch = ch; bus.cfg_div = d; bus.cfg_en = e;
    @(negedge clk);
    s_div = div_out; s_tick = tick; s_busy = busy; s_ready = bus.cfg_ready;
    for (int c = 0; c < NCH; c++) begin
      et[c] = on[c] != 0 && age[c] == 0;
      ed[c] = on[c] != 0 && age[c] < n[c] / 2;
      eb[c] = hp[c] != 0;
    end
    chk("div_out", s_div, ed);
    chk("tick", s_tick, et);
    chk("busy", s_busy, eb);
    chk("cfg_ready", {3'b0, s_ready}, {3'b0, hp[ch] == 0});
    @(posedge clk);
    m_step(v, int'(ch), int'(d), e);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 2'd0, 16'd0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 1};
    tbl[1]  = '{1, 0, 4,  1, 4'b0000, 4'b0000, 4'b0000, 1};
    tbl[2]  = '{0, 0, 0,  0, 4'b0001, 4'b0001, 4'b0000, 1};
    tbl[3]  = '{0, 0, 0,  0, 4'b0001, 4'b0000, 4'b0000, 1};
    tbl[4]  = '{0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 1};
    tbl[5]  = '{0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 1};
    tbl[6]  = '{0, 0, 0,  0, 4'b0001, 4'b0001, 4'b0000, 1};
    tbl[7]  = '{1, 0, 10, 1, 4'b0001, 4'b0000, 4'b0000, 1};
    tbl[8]  = '{0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0001, 0};
    tbl[9]  = '{0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0001, 0};
    tbl[10] = '{0, 0, 0,  0, 4'b0001, 4'b0001, 4'b0000, 1};
    tbl[11] = '{0, 0, 0,  0, 4'b0001, 4'b0000, 4'b0000, 1};
    bus.cfg_valid = 0; bus.cfg_ch = 0; bus.cfg_div = 0; bus.cfg_en = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].e);
      chk($sformatf("tbl%0d_div", i), s_div, tbl[i].xd);
      chk($sformatf("tbl%0d_tick", i), s_tick, tbl[i].xt);
      chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].xb);
      chk($sformatf("tbl%0d_ready", i), {3'b0, s_ready}, {3'b0, tbl[i].xr});
    end
    cyc(1'b1, 2'd1, 16'd5, 1'b1);
    idle(12);
    cyc(1'b1, 2'd2, 16'd6, 1'b1);
    idle(2);
    cyc(1'b1, 2'd2, 16'd6, 1'b0);
    idle(10);
    chk("ch2_off", {2'b0, s_div[2], s_tick[2]}, 4'b0);
    cyc(1'b1, 2'd3, 16'd0, 1'b1);
    idle(4);
    for (int k = 0; k < 20 && !(on[1] != 0 && age[1] == n[1] - 1); k++) idle(1);
    cyc(1'b1, 2'd1, 16'd3, 1'b1);
    idle(1);
    chk("bypass_busy", {3'b0, s_busy[1]}, 4'b0);
    chk("bypass_tick", {3'b0, s_tick[1]}, 4'b1);
    idle(6);
    cyc(1'b1, 2'd3, 16'd1, 1'b1);
    idle(6);
    for (int k = 0; k < 20 && on[0] != 0 && age[0] == n[0] - 1; k++) idle(1);
    cyc(1'b1, 2'd0, 16'd7, 1'b1);
    idle(1);
    chk("pend_before_rst", {3'b0, s_busy[0]}, 4'b1);
    rst_n = 1'b0;
    #2;
    chk("rst_div", div_out, 4'b0);
    chk("rst_tick", tick, 4'b0);
    chk("rst_busy", busy, 4'b0);
    chk("rst_ready", {3'b0, bus.cfg_ready}, 4'b1);
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 9)),
          $urandom_range(0, 3) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
